nn_vector_sequencer: RTL and testbench
======================================

Name: nn_vector_sequencer

Overview:
- Drives the FeedForwardNN input side (x0..x3) and consumes its output side (y0, y1).
- Collects four signed samples from an upstream valid/ready stream into shadow registers.
- Commits all four to the NN at once as a coherent vector, holds it stable for a fixed settle time, then captures y0/y1 as a tagged result on a downstream valid/ready stream.

Parameters:
- DW, 9, sample width in bits (signed two's complement), matching the NN x inputs.
- HOLD_CYCLES, 9, clock edges between vector commit and y0/y1 capture; must be ≥1.
- ID_W, 8, width of the frame sequence number.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high; all state is cleared immediately on assertion.
- flush  in  1  synchronous abort; discards any partial or in-flight frame.
- in_valid  in  1  upstream sample valid.
- in_data  in  DW  upstream signed sample; order within a frame is x0, x1, x2, x3.
- in_ready  out  1  sequencer can accept a sample.
- x0, x1, x2, x3  out  DW each  signed vector driven to the NN; registered.
- nn_y0, nn_y1  in  1 each  NN outputs.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_class  out  2  captured {nn_y1, nn_y0}.
- out_id  out  ID_W  frame sequence number of the result.
- busy  out  1  high whenever the state is not LOAD, or idx≠0.

Behaviour:
- States:
  - LOAD: collect samples.
  - SETTLE: hold the vector while the NN settles.
  - RESULT: present the result until it is accepted.
- Reset values: state LOAD; idx 0; shadow registers 0; x0..x3 0; out_valid 0; out_class 0; out_id 0; frame counter 0; settle counter 0; in_ready reflects LOAD, so it is 1.
- in_ready = (state==LOAD). It is combinational from state only, never from in_valid.
- LOAD:
  - A sample is accepted on an edge with in_valid&in_ready. It is written to shadow[idx], and idx increments.
  - On acceptance with idx==3: x0..x3 take shadow[0..2] plus in_data in the same edge, idx wraps to 0, the settle counter loads HOLD_CYCLES-1, and the state moves to SETTLE.
  - x0..x3 never change outside this commit edge, so the NN never sees a partially updated vector.
- SETTLE:
  - The counter decrements each edge.
  - On the edge where the counter==0: out_class <= {nn_y1, nn_y0}, out_id <= frame counter, frame counter increments (wrapping modulo 2^ID_W), out_valid <= 1, and the state moves to RESULT.
  - Commit-to-capture latency is exactly HOLD_CYCLES edges.
- RESULT:
  - out_valid stays high, and out_class/out_id stay stable, until out_valid&out_ready.
  - On that edge out_valid <= 0 and the state moves to LOAD.
  - The first new sample can be accepted on the following edge; there is no bypass.
- flush, which has priority over every transition except RST:
  - state <= LOAD, idx <= 0, out_valid <= 0, settle counter <= 0.
  - x0..x3, shadow registers and the frame counter are retained.
  - A sample presented on the same edge as flush is dropped.
  - A result being handshaken on the same edge as flush counts as consumed; no retransmit.
- RST mid-frame: immediate return to the reset values. Any partial frame is lost, and the frame counter restarts at 0.
- No arithmetic on the samples: widths pass through unchanged and signedness is preserved.
- in_valid asserted outside LOAD is ignored.

Decomposition:
- Shared package nn_pkg:
  - DW default, HOLD_CYCLES default.
  - State enum {LOAD, SETTLE, RESULT}.
  - Typedef sample_t = signed [DW-1:0].
- One natural sub-module: nn_settle_timer. It is a loadable down-counter with a done pulse, reusable by other NN-side blocks.
- Everything else stays flat in nn_vector_sequencer.

Test Plan:
- Reset, then stream 196, 243, 106, 149 with out_ready=1 and the NN model returning y1y0=2'b10:
  - x0..x3 change only on the 4th acceptance edge.
  - out_valid rises exactly 9 edges later, with out_class=2, out_id=0.
- Two back-to-back frames (196, 243, 106, 149 then 13, 37, 128, 160), out_ready=1:
  - in_ready is low for 10 edges between the frames.
  - The second result has out_id=1.
  - The second frame's first sample is accepted the edge after the first result handshake.
- Hold out_ready=0 for 5 edges after out_valid:
  - out_valid, out_class and out_id stay stable.
  - in_valid is ignored throughout.
  - Raising out_ready completes the handshake in one edge.
- After 2 samples are accepted, pulse flush together with in_valid:
  - idx returns to 0 and x0..x3 are unchanged.
  - The next 4 samples form the committed vector.
  - out_id continues from its prior value.
- Assert RST asynchronously mid-SETTLE (e.g. counter=4):
  - Outputs are 0 immediately, before the next edge; in_ready=1.
  - The next completed frame reports out_id=0.
- Signed boundary: stream -256, 255, -1, 0:
  - x0..x3 equal 9'h100, 9'h0FF, 9'h1FF, 9'h000 bit-exact.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared types and defaults for NN-side blocks.
// Sample width, settle time, sequencer states.
package nn_pkg;

  localparam int NN_DW   = 9;
  localparam int NN_HOLD = 9;
  localparam int NN_ID_W = 8;

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    RESULT
  } state_t;

  typedef logic signed [NN_DW-1:0] sample_t;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_settle_timer.sv
// nn_settle_timer: loadable down-counter.
// done is high while enabled and the count is 0.
module nn_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = en && (cnt == '0);

  // clear beats load; counting stops at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && cnt != '0)
      cnt <= cnt - W'(1);
  end

endmodule

// File: rtl/nn_vector_sequencer.sv
// nn_vector_sequencer: gathers 4 samples, commits
// them to the NN, waits, then returns {y1,y0}.
module nn_vector_sequencer
  import nn_pkg::*;
#(
  parameter int DW          = NN_DW,
  parameter int HOLD_CYCLES = NN_HOLD,
  parameter int ID_W        = NN_ID_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic signed [DW-1:0] x0,
  output logic signed [DW-1:0] x1,
  output logic signed [DW-1:0] x2,
  output logic signed [DW-1:0] x3,
  input  logic                 nn_y0,
  input  logic                 nn_y1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_class,
  output logic [ID_W-1:0]      out_id,
  output logic                 busy
);

  localparam int CW = cnt_w(HOLD_CYCLES);

  state_t                state;
  logic [1:0]            idx;
  logic signed [DW-1:0]  shadow [0:2];
  logic [ID_W-1:0]       fcnt;
  logic                  commit;
  logic                  tdone;

  assign in_ready = (state == LOAD);
  assign busy     = (state != LOAD) || (idx != 2'd0);
  assign commit   = in_ready && in_valid &&
                    (idx == 2'd3);

  nn_settle_timer #(
    .W(CW)
  ) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .clr      (flush),
    .load     (commit),
    .load_val (CW'(HOLD_CYCLES - 1)),
    .en       (state == SETTLE),
    .done     (tdone)
  );

  // frame FSM: collect, commit, settle, hand off
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= LOAD;
      idx       <= 2'd0;
      shadow    <= '{default: '0};
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
      out_valid <= 1'b0;
      out_class <= 2'b00;
      out_id    <= '0;
      fcnt      <= '0;
    end else if (flush) begin
      state     <= LOAD;
      idx       <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            if (idx == 2'd3) begin
              x0    <= shadow[0];
              x1    <= shadow[1];
              x2    <= shadow[2];
              x3    <= in_data;
              idx   <= 2'd0;
              state <= SETTLE;
            end else begin
              shadow[idx] <= in_data;
              idx         <= idx + 2'd1;
            end
          end
        end
        SETTLE: begin
          if (tdone) begin
            out_class <= {nn_y1, nn_y0};
            out_id    <= fcnt;
            fcnt      <= fcnt + ID_W'(1);
            out_valid <= 1'b1;
            state     <= RESULT;
          end
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_vector_sequencer.sv
// tb_nn_vector_sequencer: directed + random run
// against a frame-level model of the sequencer.
module tb_nn_vector_sequencer;

  localparam int HOLD = 9;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] in_data = '0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic [8:0] x0, x1, x2, x3;
  logic       out_valid;
  logic [1:0] out_class;
  logic [7:0] out_id;
  logic       busy;

  logic       fix_en = 1'b1;
  logic [1:0] fix_val = 2'b10;
  logic [1:0] nn_o;

  int total = 0;
  int bad = 0;

  // model state
  logic [8:0] mq [$];
  logic [8:0] mx [4];
  bit         mwait, mres;
  int         mcommit;
  logic [1:0] mcls;
  logic [7:0] mid, mfr;
  int         n = 0;

  // event bookkeeping
  int lowrun = 0;
  int lastrun = 0;
  int last_hs = 0;
  int last_acc = 0;
  int c;

  always #5 CLK = ~CLK;

  function automatic logic [1:0] nnf(
    input logic [8:0] a, b, d2, d3);
    return {a[0] ^ d2[3] ^ d3[8],
            b[1] ^ d3[0] ^ a[5]};
  endfunction

  assign nn_o = fix_en ? fix_val
              : nnf(x0, x1, x2, x3);

  nn_vector_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .nn_y0     (nn_o[0]),
    .nn_y1     (nn_o[1]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_id    (out_id),
    .busy      (busy)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) mx[i] = '0;
    mwait = 0;
    mres  = 0;
    mcls  = '0;
    mid   = '0;
    mfr   = '0;
  endtask

  // one clock edge of the frame-level model
  task automatic model_edge();
    n++;
    if (RST) begin
      model_reset();
    end else if (flush) begin
      mq.delete();
      mwait = 0;
      mres  = 0;
    end else if (mres) begin
      if (out_ready) mres = 0;
    end else if (mwait) begin
      if (n - mcommit == HOLD) begin
        mcls = fix_en ? fix_val
             : nnf(mx[0], mx[1], mx[2], mx[3]);
        mid  = mfr;
        mfr  = mfr + 8'd1;
        mres = 1;
        mwait = 0;
      end
    end else if (in_valid) begin
      mq.push_back(in_data);
      if (mq.size() == 4) begin
        for (int i = 0; i < 4; i++) mx[i] = mq[i];
        mq.delete();
        mwait = 1;
        mcommit = n;
      end
    end
  endtask

  task automatic compare();
    chk("in_ready", in_ready, !(mwait || mres));
    chk("busy", busy,
        mwait || mres || (mq.size() != 0));
    chk("out_valid", out_valid, mres);
    chk("x0", x0, mx[0]);
    chk("x1", x1, mx[1]);
    chk("x2", x2, mx[2]);
    chk("x3", x3, mx[3]);
    chk("out_class", out_class, mcls);
    chk("out_id", out_id, mid);
    if (!in_ready) lowrun++;
    else begin
      if (lowrun > 0) lastrun = lowrun;
      lowrun = 0;
    end
  endtask

  task automatic tick();
    bit hs, acc;
    hs  = out_valid && out_ready && !flush;
    acc = in_valid && in_ready && !flush;
    @(posedge CLK);
    model_edge();
    if (hs) last_hs = n;
    if (acc) last_acc = n;
    @(negedge CLK);
    compare();
  endtask

  task automatic push(input int v);
    int b;
    b = 0;
    in_valid = 1'b1;
    in_data  = v[8:0];
    while (!in_ready && b < 100) begin
      tick();
      b++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL push_wait: got busy want ready");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL wait_valid: got 0 want 1");
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    compare();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_id", out_id, 0);
    RST = 1'b0;

    // frame 1, constant NN answer 2'b10
    push(196);
    push(243);
    push(106);
    chk("x0_pre", x0, 0);
    chk("x3_pre", x3, 0);
    push(149);
    chk("x0_f1", x0, 196);
    chk("x1_f1", x1, 243);
    chk("x2_f1", x2, 106);
    chk("x3_f1", x3, 149);
    wait_valid(c);
    chk("lat_f1", c, 9);
    chk("cls_f1", out_class, 2);
    chk("id_f1", out_id, 0);

    // frame 2 back to back
    push(13);
    chk("gap", lastrun, 10);
    chk("acc_after_hs", last_acc - last_hs, 1);
    push(37);
    push(128);
    push(160);
    chk("x2_f2", x2, 128);
    wait_valid(c);
    chk("id_f2", out_id, 1);

    // stall the result, spam samples
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 9'($urandom);
      tick();
      chk("stall_v", out_valid, 1);
      chk("stall_id", out_id, 1);
      chk("stall_cls", out_class, 2);
      chk("stall_rdy", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hs_v", out_valid, 0);
    chk("hs_rdy", in_ready, 1);

    // flush after two samples
    fix_en = 1'b0;
    push(11);
    push(22);
    in_valid = 1'b1;
    in_data  = 9'd99;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_x0", x0, 13);
    chk("fl_x3", x3, 160);
    push(5);
    push(6);
    push(7);
    push(8);
    chk("fl_x0n", x0, 5);
    chk("fl_x1n", x1, 6);
    chk("fl_x3n", x3, 8);
    wait_valid(c);
    chk("id_f3", out_id, 2);

    // async reset mid settle
    push(1);
    push(2);
    push(3);
    push(4);
    repeat (4) tick();
    #2 RST = 1'b1;
    #1;
    model_reset();
    chk("ar_x0", x0, 0);
    chk("ar_x3", x3, 0);
    chk("ar_v", out_valid, 0);
    chk("ar_id", out_id, 0);
    chk("ar_rdy", in_ready, 1);
    chk("ar_busy", busy, 0);
    tick();
    RST = 1'b0;
    push(40);
    push(41);
    push(42);
    push(43);
    wait_valid(c);
    chk("lat_ar", c, 9);
    chk("id_ar", out_id, 0);

    // signed boundary values
    push(-256);
    push(255);
    push(-1);
    push(0);
    chk("sx0", x0, 9'h100);
    chk("sx1", x1, 9'h0FF);
    chk("sx2", x2, 9'h1FF);
    chk("sx3", x3, 9'h000);
    wait_valid(c);
    chk("id_s", out_id, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 9'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush    = 1'b0;
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
